// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register file geometry and named register indices.
// Also used by the decoder and the hazard logic.
package mips_pkg;
    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;
endpackage

// File: rtl/gpr_read_port.sv
// One combinational read port of the GPR file: applies the $0 rule and the
// same-cycle writeback bypass on top of the stored register value.
module gpr_read_port
    import mips_pkg::*;
#(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic [DW-1:0] stored,
    output logic [DW-1:0] rd
);
    // $0 is checked first so a write to $0 can never leak through the bypass.
    always_comb begin
        rd = stored;
        if (ra == AW'(REG_ZERO))
            rd = '0;
        else if ((BYPASS != 0) && we && (wa == ra))
            rd = wd;
    end
endmodule

// File: rtl/gpr_file.sv
// 32x32 MIPS general-purpose register file: two combinational read ports with
// optional writeback bypass, async-clear storage, commit counter and trace line.
module gpr_file
    import mips_pkg::*;
#(
    parameter int NREG   = mips_pkg::NREG,
    parameter int DW     = mips_pkg::DW,
    parameter int BYPASS = 1,
    parameter int TRACE  = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [31:0]   pc,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [31:0]   wr_cnt
);
    logic [DW-1:0] regs [NREG];
    logic          commit;
    logic          byp_we;

    // we gates the address compare, so X on wa/wd with we=0 cannot reach storage.
    assign commit = we && (wa != AW'(REG_ZERO));
    // While reset is held nothing may be forwarded; storage is already zero.
    assign byp_we = we && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            wr_cnt <= '0;
        end else if (commit) begin
            regs[wa] <= wd;
            wr_cnt   <= wr_cnt + 32'd1;
        end
    end

    gpr_read_port #(.AW(AW), .DW(DW), .BYPASS(BYPASS)) u_port1 (
        .ra(ra1), .wa(wa), .we(byp_we), .wd(wd), .stored(regs[ra1]), .rd(rd1)
    );

    gpr_read_port #(.AW(AW), .DW(DW), .BYPASS(BYPASS)) u_port2 (
        .ra(ra2), .wa(wa), .we(byp_we), .wd(wd), .stored(regs[ra2]), .rd(rd2)
    );

`ifndef SYNTHESIS
    // Writes to $0 are still logged; the external log checker expects them.
    if (TRACE != 0) begin : g_trace
        always @(posedge clk) begin
            if (rst_n && we)
                $display("@%h: $%d <= %h", pc, wa, wd);
        end
    end
`endif
endmodule
